// File: rtl/regfile_wb_scheduler.sv
// ============================================================================
// Module   : regfile_wb_scheduler
// Purpose  : Arbitrates the register-file write port between WB and the
//            multi-cycle unit; tracks pending multi-cycle destinations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_scheduler #(
   parameter int WORD_SIZE = 16,
   parameter int NUM_REGS  = 4,
   parameter int ADDR_W    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 a_valid,
   input  logic [ADDR_W-1:0]    a_rd,
   input  logic [WORD_SIZE-1:0] a_data,
   output logic                 a_ready,
   input  logic                 b_valid,
   input  logic [ADDR_W-1:0]    b_rd,
   input  logic [WORD_SIZE-1:0] b_data,
   output logic                 b_ready,
   input  logic                 resv_valid,
   input  logic [ADDR_W-1:0]    resv_rd,
   output logic                 resv_ready,
   input  logic [ADDR_W-1:0]    rs1,
   input  logic [ADDR_W-1:0]    rs2,
   output logic                 hazard_stall,
   output logic [NUM_REGS-1:0]  busy_vec,
   output logic                 rf_we,
   output logic [ADDR_W-1:0]    rf_wr_addr,
   output logic [WORD_SIZE-1:0] rf_wr_data
);

   localparam logic c_GRANT_A = 1'b0;
   localparam logic c_GRANT_B = 1'b1;

   logic                 r_last_grant;
   logic [NUM_REGS-1:0]  r_busy;
   logic                 r_we;
   logic [ADDR_W-1:0]    r_wr_addr;
   logic [WORD_SIZE-1:0] r_wr_data;

   logic                 w_conflict;
   logic                 w_grant_a;
   logic                 w_grant_b;
   logic                 w_resv_ok;
   logic [NUM_REGS-1:0]  w_busy_nxt;

   assign w_conflict = a_valid && b_valid;

   // Nothing is accepted while reset is asserted, so no request is lost.
   always_comb begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
      if (reset) begin
         if (w_conflict) begin
            if (r_last_grant == c_GRANT_B) w_grant_a = 1'b1;
            else                           w_grant_b = 1'b1;
         end else begin
            w_grant_a = a_valid;
            w_grant_b = b_valid;
         end
      end
   end

   assign w_resv_ok = reset && resv_valid && !r_busy[resv_rd];

   // Clear first, then set: a same-register clear+reserve is only possible
   // on a protocol-error write, where the new reservation must survive.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_grant_b) w_busy_nxt[b_rd]    = 1'b0;
      if (w_resv_ok) w_busy_nxt[resv_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last_grant <= c_GRANT_B;
         r_busy       <= '0;
         r_we         <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_we   <= w_grant_a || w_grant_b;
         if (w_grant_a) begin
            r_wr_addr <= a_rd;
            r_wr_data <= a_data;
         end else if (w_grant_b) begin
            r_wr_addr <= b_rd;
            r_wr_data <= b_data;
         end
         if (w_conflict) r_last_grant <= w_grant_a ? c_GRANT_A : c_GRANT_B;
      end
   end

   assign a_ready      = w_grant_a;
   assign b_ready      = w_grant_b;
   assign resv_ready   = w_resv_ok;
   assign hazard_stall = r_busy[rs1] || r_busy[rs2] || (resv_valid && r_busy[resv_rd]);
   assign busy_vec     = r_busy;
   assign rf_we        = r_we;
   assign rf_wr_addr   = r_wr_addr;
   assign rf_wr_data   = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
// ============================================================================
// Module   : tb_regfile_wb_scheduler
// Purpose  : Directed self-checking bench for regfile_wb_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid, resv_valid;
   logic [1:0]  a_rd, b_rd, resv_rd, rs1, rs2;
   logic [15:0] a_data, b_data;
   logic        a_ready, b_ready, resv_ready, hazard_stall, rf_we;
   logic [3:0]  busy_vec;
   logic [1:0]  rf_wr_addr;
   logic [15:0] rf_wr_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_wb_scheduler #(.WORD_SIZE(16), .NUM_REGS(4), .ADDR_W(2)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
      .resv_valid(resv_valid), .resv_rd(resv_rd), .resv_ready(resv_ready),
      .rs1(rs1), .rs2(rs2), .hazard_stall(hazard_stall), .busy_vec(busy_vec),
      .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
   );

   // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_valid = 0; b_valid = 0; resv_valid = 0;
      a_rd = 0; b_rd = 0; resv_rd = 0; rs1 = 0; rs2 = 0;
      a_data = 0; b_data = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 0;
      tick();
      reset = 1;
   endtask

   task automatic test_reset();
      reset = 0;
      for (int i = 0; i < 2; i++) begin
         a_valid = 1'($urandom); b_valid = 1'($urandom); resv_valid = 1'($urandom);
         a_rd = 2'($urandom); b_rd = 2'($urandom); resv_rd = 2'($urandom);
         a_data = 16'($urandom); b_data = 16'($urandom);
         rs1 = 2'($urandom); rs2 = 2'($urandom);
         tick();
      end
      idle_inputs();
      #1;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_we); end
      total++; if (busy_vec !== 4'b0000) begin bad++; $display("FAIL reset_busy got=%b exp=0000", busy_vec); end
      total++; if (rf_wr_addr !== 2'd0 || rf_wr_data !== 16'h0) begin bad++; $display("FAIL reset_addr_data got=%0d/%h exp=0/0000", rf_wr_addr, rf_wr_data); end
      total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", a_ready, b_ready); end
      reset = 1;
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL post_reset_idle_we got=%b exp=0", rf_we); end
   endtask

   task automatic test_single();
      a_valid = 1; a_rd = 2; a_data = 16'h1234;
      #1;
      total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("FAIL single_ready got=%b%b exp=10", a_ready, b_ready); end
      tick();
      a_valid = 0;
      total++; if (rf_we !== 1'b1 || rf_wr_addr !== 2'd2 || rf_wr_data !== 16'h1234) begin
         bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/2/1234", rf_we, rf_wr_addr, rf_wr_data); end
      tick();
      total++; if (rf_we !== 1'b0 || rf_wr_addr !== 2'd2 || rf_wr_data !== 16'h1234) begin
         bad++; $display("FAIL single_hold got=%b/%0d/%h exp=0/2/1234", rf_we, rf_wr_addr, rf_wr_data); end
   endtask

   task automatic test_conflict();
      logic exp_a;
      do_reset();
      a_valid = 1; a_rd = 1; a_data = 16'hAAAA;
      b_valid = 1; b_rd = 3; b_data = 16'hBBBB;
      for (int i = 0; i < 4; i++) begin
         exp_a = (i % 2 == 0);
         #1;
         total++; if (a_ready !== exp_a || b_ready !== !exp_a) begin
            bad++; $display("FAIL conflict_grant%0d got=%b%b exp=%b%b", i, a_ready, b_ready, exp_a, !exp_a); end
         tick();
         total++; if (rf_we !== 1'b1 || rf_wr_addr !== (exp_a ? 2'd1 : 2'd3) ||
                      rf_wr_data !== (exp_a ? 16'hAAAA : 16'hBBBB)) begin
            bad++; $display("FAIL conflict_write%0d got=%b/%0d/%h", i, rf_we, rf_wr_addr, rf_wr_data); end
      end
      idle_inputs();
      tick();
      total++; if (rf_we !== 1'b0 || busy_vec !== 4'b0000) begin
         bad++; $display("FAIL conflict_end got=%b/%b exp=0/0000", rf_we, busy_vec); end
   endtask

   task automatic test_scoreboard();
      resv_valid = 1; resv_rd = 1;
      #1;
      total++; if (resv_ready !== 1'b1 || hazard_stall !== 1'b0) begin
         bad++; $display("FAIL sb_resv1 got=%b/%b exp=1/0", resv_ready, hazard_stall); end
      tick();
      resv_valid = 0;
      total++; if (busy_vec !== 4'b0010) begin bad++; $display("FAIL sb_busy got=%b exp=0010", busy_vec); end
      rs1 = 1;
      #1;
      total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL sb_stall_rs1 got=%b exp=1", hazard_stall); end
      rs1 = 0; resv_valid = 1; resv_rd = 1;
      #1;
      total++; if (resv_ready !== 1'b0 || hazard_stall !== 1'b1) begin
         bad++; $display("FAIL sb_waw got=%b/%b exp=0/1", resv_ready, hazard_stall); end
      resv_valid = 0; rs2 = 1;
      b_valid = 1; b_rd = 1; b_data = 16'h00FF;
      #1;
      total++; if (b_ready !== 1'b1 || hazard_stall !== 1'b1) begin
         bad++; $display("FAIL sb_bhs got=%b/%b exp=1/1", b_ready, hazard_stall); end
      tick();
      b_valid = 0;
      total++; if (busy_vec !== 4'b0000 || hazard_stall !== 1'b0) begin
         bad++; $display("FAIL sb_clear got=%b/%b exp=0000/0", busy_vec, hazard_stall); end
      total++; if (rf_we !== 1'b1 || rf_wr_addr !== 2'd1 || rf_wr_data !== 16'h00FF) begin
         bad++; $display("FAIL sb_write got=%b/%0d/%h exp=1/1/00ff", rf_we, rf_wr_addr, rf_wr_data); end
      rs2 = 0;
   endtask

   task automatic test_clear_reserve();
      resv_valid = 1; resv_rd = 0;
      tick();
      resv_valid = 0;
      total++; if (busy_vec !== 4'b0001) begin bad++; $display("FAIL cr_setup got=%b exp=0001", busy_vec); end
      b_valid = 1; b_rd = 0; b_data = 16'h0BAD; resv_valid = 1; resv_rd = 0;
      #1;
      total++; if (b_ready !== 1'b1 || resv_ready !== 1'b0) begin
         bad++; $display("FAIL cr_same got=%b/%b exp=1/0", b_ready, resv_ready); end
      tick();
      b_valid = 0;
      total++; if (busy_vec !== 4'b0000 || resv_ready !== 1'b1) begin
         bad++; $display("FAIL cr_retry got=%b/%b exp=0000/1", busy_vec, resv_ready); end
      tick();
      total++; if (busy_vec !== 4'b0001) begin bad++; $display("FAIL cr_accept got=%b exp=0001", busy_vec); end
      b_valid = 1; b_rd = 0; b_data = 16'h0C0D; resv_valid = 1; resv_rd = 2;
      #1;
      total++; if (b_ready !== 1'b1 || resv_ready !== 1'b1) begin
         bad++; $display("FAIL cr_diff got=%b/%b exp=1/1", b_ready, resv_ready); end
      tick();
      idle_inputs();
      total++; if (busy_vec !== 4'b0100) begin bad++; $display("FAIL cr_diff_busy got=%b exp=0100", busy_vec); end
      b_valid = 1; b_rd = 2; b_data = 16'h0;
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      resv_valid = 1; resv_rd = 1;
      tick();
      resv_rd = 3;
      tick();
      resv_valid = 0;
      // Conflict lands on B (last was B after conflict test? no: make A win first)
      a_valid = 1; a_rd = 0; a_data = 16'h1111; b_valid = 1; b_rd = 0; b_data = 16'h2222;
      #1;
      total++; if (a_ready !== 1'b1 || busy_vec !== 4'b1010) begin
         bad++; $display("FAIL rm_setup got=%b/%b exp=1/1010", a_ready, busy_vec); end
      tick();
      a_valid = 0; b_valid = 1; b_rd = 1; b_data = 16'h3333;
      reset = 0;
      tick();
      reset = 1; b_valid = 0;
      total++; if (busy_vec !== 4'b0000 || rf_we !== 1'b0) begin
         bad++; $display("FAIL rm_clear got=%b/%b exp=0000/0", busy_vec, rf_we); end
      a_valid = 1; a_rd = 2; a_data = 16'h4444; b_valid = 1; b_rd = 3; b_data = 16'h5555;
      #1;
      total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         bad++; $display("FAIL rm_grant got=%b%b exp=10", a_ready, b_ready); end
      tick();
      idle_inputs();
      total++; if (rf_we !== 1'b1 || rf_wr_addr !== 2'd2 || rf_wr_data !== 16'h4444) begin
         bad++; $display("FAIL rm_write got=%b/%0d/%h exp=1/2/4444", rf_we, rf_wr_addr, rf_wr_data); end
   endtask

   initial begin
      idle_inputs();
      reset = 0;
      #1;
      test_reset();
      test_single();
      test_conflict();
      test_scoreboard();
      test_clear_reserve();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
